// File: rtl/heap_level_mem.sv
// Per-level storage for the pipelined heap sorter: NUM_CH banks with valid bits,
// parent-side lanes, a shared child-side port, forwarding, flush and occupancy tracking.
module heap_level_mem #(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 5,
    parameter  int LEVEL      = 1,
    parameter  int NUM_CH     = 2,
    parameter  int FWD        = 1,
    localparam int MEM_SIZE   = ((1 << LEVEL) > 2) ? (1 << LEVEL) : 2,
    localparam int SEL_W      = $clog2(NUM_CH),
    localparam int OCC_W      = $clog2(NUM_CH * MEM_SIZE + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] up_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] up_din,
    input  logic [NUM_CH-1:0]            up_we,
    output logic [NUM_CH*DATA_WIDTH-1:0] up_dout,
    output logic [NUM_CH-1:0]            up_dval,
    input  logic [ADDR_WIDTH-1:0]        dn_addr,
    input  logic [SEL_W-1:0]             dn_sel,
    input  logic [DATA_WIDTH-1:0]        dn_din,
    input  logic                         dn_we,
    input  logic                         dn_clr,
    output logic [DATA_WIDTH-1:0]        dn_dout,
    output logic                         dn_dval,
    output logic [OCC_W-1:0]             occ,
    output logic [7:0]                   coll_cnt,
    output logic                         addr_err
);

    localparam int IDX_W = $clog2(MEM_SIZE);

    logic [DATA_WIDTH-1:0]             mem [NUM_CH][MEM_SIZE];
    logic [NUM_CH-1:0][MEM_SIZE-1:0]   valid_q;
    logic [NUM_CH-1:0][MEM_SIZE-1:0]   valid_nxt;

    logic [ADDR_WIDTH-1:0] ua [NUM_CH];
    logic [DATA_WIDTH-1:0] ud [NUM_CH];
    logic [NUM_CH-1:0]     up_wr;
    logic                  dn_wr;
    logic                  dn_cl;
    logic                  coll;
    logic                  err_set;
    logic                  dn_sel_ok;
    logic                  dn_in;
    logic [DATA_WIDTH-1:0] up_rd [NUM_CH];
    logic [NUM_CH-1:0]     up_rv;
    logic [DATA_WIDTH-1:0] dn_rd;
    logic                  dn_rv;
    logic [OCC_W-1:0]      occ_nxt;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < (ADDR_WIDTH + 1)'(MEM_SIZE);
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    always_comb begin
        up_wr     = '0;
        dn_wr     = 1'b0;
        dn_cl     = 1'b0;
        coll      = 1'b0;
        err_set   = 1'b0;
        dn_sel_ok = {1'b0, dn_sel} < (SEL_W + 1)'(NUM_CH);
        dn_in     = in_range(dn_addr);
        for (int unsigned b = 0; b < NUM_CH; b++) begin
            ua[b] = up_addr[b*ADDR_WIDTH +: ADDR_WIDTH];
            ud[b] = up_din[b*DATA_WIDTH +: DATA_WIDTH];
        end

        // Flush suppresses every write, so reads in that cycle see pre-flush state.
        if (!flush) begin
            for (int unsigned b = 0; b < NUM_CH; b++) begin
                up_wr[b] = up_we[b] & in_range(ua[b]);
                if (up_we[b] && !in_range(ua[b]))
                    err_set = 1'b1;
            end
            if (dn_we && dn_sel_ok) begin
                coll = up_we[dn_sel] && (ua[dn_sel] == dn_addr);
                if (!dn_in)
                    err_set = 1'b1;
                else if (!coll) begin
                    dn_wr = !dn_clr;
                    dn_cl = dn_clr;
                end
            end
        end

        valid_nxt = valid_q;
        for (int unsigned b = 0; b < NUM_CH; b++)
            if (up_wr[b])
                valid_nxt[b][idx(ua[b])] = 1'b1;
        if (dn_wr)
            valid_nxt[dn_sel][idx(dn_addr)] = 1'b1;
        if (dn_cl)
            valid_nxt[dn_sel][idx(dn_addr)] = 1'b0;

        occ_nxt = '0;
        for (int unsigned b = 0; b < NUM_CH; b++)
            for (int unsigned e = 0; e < MEM_SIZE; e++)
                occ_nxt = occ_nxt + OCC_W'(valid_nxt[b][e]);

        for (int unsigned b = 0; b < NUM_CH; b++) begin
            up_rd[b] = '0;
            up_rv[b] = 1'b0;
            if (in_range(ua[b])) begin
                up_rd[b] = mem[b][idx(ua[b])];
                up_rv[b] = valid_q[b][idx(ua[b])];
                if (FWD != 0) begin
                    up_rv[b] = valid_nxt[b][idx(ua[b])];
                    if (up_wr[b])
                        up_rd[b] = ud[b];
                    else if (dn_wr && 32'(dn_sel) == b && dn_addr == ua[b])
                        up_rd[b] = dn_din;
                end
            end
        end

        dn_rd = '0;
        dn_rv = 1'b0;
        if (dn_sel_ok && dn_in) begin
            dn_rd = mem[dn_sel][idx(dn_addr)];
            dn_rv = valid_q[dn_sel][idx(dn_addr)];
            if (FWD != 0) begin
                dn_rv = valid_nxt[dn_sel][idx(dn_addr)];
                if (dn_wr)
                    dn_rd = dn_din;
                else if (up_wr[dn_sel] && ua[dn_sel] == dn_addr)
                    dn_rd = ud[dn_sel];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= '0;
            up_dout  <= '0;
            up_dval  <= '0;
            dn_dout  <= '0;
            dn_dval  <= 1'b0;
            occ      <= '0;
            coll_cnt <= '0;
            addr_err <= 1'b0;
        end else begin
            valid_q <= flush ? '0 : valid_nxt;
            occ     <= flush ? '0 : occ_nxt;
            for (int unsigned b = 0; b < NUM_CH; b++)
                up_dout[b*DATA_WIDTH +: DATA_WIDTH] <= up_rd[b];
            up_dval <= up_rv;
            dn_dout <= dn_rd;
            dn_dval <= dn_rv;
            if (coll && coll_cnt != 8'hFF)
                coll_cnt <= coll_cnt + 8'd1;
            if (err_set)
                addr_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int unsigned b = 0; b < NUM_CH; b++)
                if (up_wr[b])
                    mem[b][idx(ua[b])] <= ud[b];
            if (dn_wr)
                mem[dn_sel][idx(dn_addr)] <= dn_din;
        end
    end

endmodule

// File: tb/tb_heap_level_mem.sv
// Bench for heap_level_mem: directed scenarios plus randomized traffic checked
// against an entry-level model of the banks.
module tb_heap_level_mem;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int LVL = 1;
    localparam int NCH = 2;
    localparam int FW  = 1;
    localparam int MS  = 2;
    localparam int SW  = 1;
    localparam int OW  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic [NCH*AW-1:0] up_addr;
    logic [NCH*DW-1:0] up_din;
    logic [NCH-1:0]    up_we;
    logic [NCH*DW-1:0] up_dout;
    logic [NCH-1:0]    up_dval;
    logic [AW-1:0]     dn_addr;
    logic [SW-1:0]     dn_sel;
    logic [DW-1:0]     dn_din;
    logic              dn_we;
    logic              dn_clr;
    logic [DW-1:0]     dn_dout;
    logic              dn_dval;
    logic [OW-1:0]     occ;
    logic [7:0]        coll_cnt;
    logic              addr_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model state
    logic [DW-1:0] m_data [NCH][MS];
    bit            m_val  [NCH][MS];
    int            m_coll;
    bit            m_err;
    logic [DW-1:0] e_up_dout [NCH];
    bit            e_up_dval [NCH];
    bit            e_up_dchk [NCH];
    logic [DW-1:0] e_dn_dout;
    bit            e_dn_dval;
    bit            e_dn_dchk;
    int            e_occ;

    always #5 clk = ~clk;

    heap_level_mem #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .LEVEL(LVL),
        .NUM_CH(NCH),
        .FWD(FW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .up_addr(up_addr),
        .up_din(up_din),
        .up_we(up_we),
        .up_dout(up_dout),
        .up_dval(up_dval),
        .dn_addr(dn_addr),
        .dn_sel(dn_sel),
        .dn_din(dn_din),
        .dn_we(dn_we),
        .dn_clr(dn_clr),
        .dn_dout(dn_dout),
        .dn_dval(dn_dval),
        .occ(occ),
        .coll_cnt(coll_cnt),
        .addr_err(addr_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lane_addr(input int i);
        logic [NCH*AW-1:0] v;
        v = up_addr;
        return int'(v[i*AW +: AW]);
    endfunction

    // Expected outputs come from the post-write entry state (same-cycle forwarding).
    task automatic model_update();
        int a;
        int s;
        bit c;
        if (!rst_n) begin
            for (int b = 0; b < NCH; b++) begin
                for (int e = 0; e < MS; e++) m_val[b][e] = 1'b0;
                e_up_dout[b] = '0;
                e_up_dval[b] = 1'b0;
                e_up_dchk[b] = 1'b1;
            end
            e_dn_dout = '0;
            e_dn_dval = 1'b0;
            e_dn_dchk = 1'b1;
            e_occ     = 0;
            m_coll    = 0;
            m_err     = 1'b0;
            return;
        end
        if (!flush) begin
            for (int i = 0; i < NCH; i++) begin
                if (up_we[i]) begin
                    a = lane_addr(i);
                    if (a < MS) begin
                        m_data[i][a] = up_din[i*DW +: DW];
                        m_val[i][a]  = 1'b1;
                    end else m_err = 1'b1;
                end
            end
            if (dn_we && int'(dn_sel) < NCH) begin
                s = int'(dn_sel);
                a = int'(dn_addr);
                c = up_we[s] && lane_addr(s) == a;
                if (c && m_coll < 255) m_coll++;
                if (a >= MS) m_err = 1'b1;
                else if (!c) begin
                    if (dn_clr) m_val[s][a] = 1'b0;
                    else begin
                        m_data[s][a] = dn_din;
                        m_val[s][a]  = 1'b1;
                    end
                end
            end
        end
        for (int i = 0; i < NCH; i++) begin
            a = lane_addr(i);
            if (a < MS) begin
                e_up_dval[i] = m_val[i][a];
                e_up_dout[i] = m_data[i][a];
                e_up_dchk[i] = m_val[i][a];
            end else begin
                e_up_dval[i] = 1'b0;
                e_up_dout[i] = '0;
                e_up_dchk[i] = 1'b1;
            end
        end
        s = int'(dn_sel);
        a = int'(dn_addr);
        if (s < NCH && a < MS) begin
            e_dn_dval = m_val[s][a];
            e_dn_dout = m_data[s][a];
            e_dn_dchk = m_val[s][a];
        end else begin
            e_dn_dval = 1'b0;
            e_dn_dout = '0;
            e_dn_dchk = 1'b1;
        end
        if (flush)
            for (int b = 0; b < NCH; b++)
                for (int e = 0; e < MS; e++) m_val[b][e] = 1'b0;
        e_occ = 0;
        for (int b = 0; b < NCH; b++)
            for (int e = 0; e < MS; e++) e_occ += int'(m_val[b][e]);
    endtask

    task automatic check_all();
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("up_dval[%0d] cyc%0d", i, cyc), 64'(up_dval[i]), 64'(e_up_dval[i]));
            if (e_up_dchk[i])
                chk($sformatf("up_dout[%0d] cyc%0d", i, cyc), 64'(up_dout[i*DW +: DW]), 64'(e_up_dout[i]));
        end
        chk($sformatf("dn_dval cyc%0d", cyc), 64'(dn_dval), 64'(e_dn_dval));
        if (e_dn_dchk)
            chk($sformatf("dn_dout cyc%0d", cyc), 64'(dn_dout), 64'(e_dn_dout));
        chk($sformatf("occ cyc%0d", cyc), 64'(occ), 64'(e_occ));
        chk($sformatf("coll_cnt cyc%0d", cyc), 64'(coll_cnt), 64'(m_coll));
        chk($sformatf("addr_err cyc%0d", cyc), 64'(addr_err), 64'(m_err));
    endtask

    task automatic cycle();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic set_up(input int i, input int a, input logic [DW-1:0] d, input bit we);
        up_addr[i*AW +: AW] = AW'(a);
        up_din[i*DW +: DW]  = d;
        up_we[i]            = we;
    endtask

    task automatic set_dn(input int s, input int a, input logic [DW-1:0] d, input bit we, input bit clr);
        dn_sel  = SW'(s);
        dn_addr = AW'(a);
        dn_din  = d;
        dn_we   = we;
        dn_clr  = clr;
    endtask

    task automatic idle();
        rst_n  = 1'b1;
        flush  = 1'b0;
        up_we  = '0;
        dn_we  = 1'b0;
        dn_clr = 1'b0;
    endtask

    function automatic int rand_addr();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(0, 31));
        return int'($urandom_range(0, MS - 1));
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; up_addr = '0; up_din = '0; up_we = '0;
        dn_addr = '0; dn_sel = '0; dn_din = '0; dn_we = 1'b0; dn_clr = 1'b0;

        // reset, then sweep every address on all lanes
        cycle();
        cycle();
        idle();
        for (int a = 0; a <= MS; a++) begin
            for (int i = 0; i < NCH; i++) set_up(i, a, '0, 1'b0);
            for (int s = 0; s < NCH; s++) begin
                set_dn(s, a, '0, 1'b0, 1'b0);
                cycle();
            end
        end

        // parent write then child read of the same entry
        set_up(1, 1, 32'hA5A5, 1'b1);
        cycle();
        idle();
        set_dn(1, 1, '0, 1'b0, 1'b0);
        cycle();
        chk("t2 dn_dout", 64'(dn_dout), 64'h0000_A5A5);
        chk("t2 dn_dval", 64'(dn_dval), 64'd1);
        chk("t2 occ", 64'(occ), 64'd1);

        // collision: parent wins, forwarded to parent read
        set_up(0, 0, 32'h11, 1'b1);
        set_dn(0, 0, 32'h22, 1'b1, 1'b0);
        cycle();
        chk("t3 up_dout0", 64'(up_dout[DW-1:0]), 64'h11);
        chk("t3 coll_cnt", 64'(coll_cnt), 64'd1);
        idle();
        cycle();
        chk("t3 stored", 64'(dn_dout), 64'h11);

        // fill, clear one entry, flush
        for (int a = 0; a < MS; a++) begin
            for (int i = 0; i < NCH; i++) set_up(i, a, DW'(100 + 10 * i + a), 1'b1);
            cycle();
        end
        idle();
        chk("t4 occ full", 64'(occ), 64'd4);
        set_up(0, 1, '0, 1'b0);
        set_dn(0, 1, '0, 1'b1, 1'b1);
        cycle();
        chk("t4 occ after clr", 64'(occ), 64'd3);
        chk("t4 cleared dval", 64'(up_dval[0]), 64'd0);
        idle();
        flush = 1'b1;
        set_up(1, 0, 32'hDEAD, 1'b1);
        cycle();
        idle();
        chk("t4 occ after flush", 64'(occ), 64'd0);
        for (int a = 0; a < MS; a++) begin
            for (int i = 0; i < NCH; i++) set_up(i, a, '0, 1'b0);
            set_dn(a % NCH, a, '0, 1'b0, 1'b0);
            cycle();
        end

        // out-of-range write, saturating collision counter
        set_up(0, 2, 32'h77, 1'b1);
        cycle();
        idle();
        chk("t5 addr_err", 64'(addr_err), 64'd1);
        cycle();
        cycle();
        chk("t5 addr_err sticky", 64'(addr_err), 64'd1);
        for (int n = 0; n < 300; n++) begin
            set_up(0, 0, DW'(n), 1'b1);
            set_dn(0, 0, 32'hBEEF, 1'b1, 1'b0);
            cycle();
        end
        idle();
        chk("t5 coll_cnt sat", 64'(coll_cnt), 64'd255);

        // reset mid-burst
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NCH; i++) set_up(i, n % MS, $urandom, 1'b1);
            set_dn(n % NCH, (n + 1) % MS, $urandom, 1'b1, 1'b0);
            if (n == 3) rst_n = 1'b0;
            cycle();
        end
        chk("t6 occ", 64'(occ), 64'd0);
        chk("t6 up_dout", 64'(up_dout), 64'd0);
        chk("t6 coll_cnt", 64'(coll_cnt), 64'd0);
        idle();
        for (int a = 0; a < MS; a++) begin
            for (int i = 0; i < NCH; i++) set_up(i, a, '0, 1'b0);
            set_dn(0, a, '0, 1'b0, 1'b0);
            cycle();
            chk($sformatf("t6 dval a%0d", a), 64'({up_dval, dn_dval}), 64'd0);
        end

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            flush = ($urandom_range(0, 29) == 0);
            for (int i = 0; i < NCH; i++)
                set_up(i, rand_addr(), $urandom, bit'($urandom_range(0, 1)));
            set_dn(int'($urandom_range(0, NCH - 1)), rand_addr(), $urandom,
                   bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
